// File: rtl/adder_subber_seq.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with a valid/ready handshake on both sides.
// Define ADDSUB_FLAGS_EN to build the carry/overflow/zero flags; otherwise they are tied to 0.
module adder_subber_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             c_q;
  logic [KW-1:0]    k_q;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             cout;
  logic [WIDTH-1:0] res_next;
  logic             last;

  always_comb begin
    a_chunk             = a_q[k_q*CHUNK +: CHUNK];
    b_chunk             = b_q[k_q*CHUNK +: CHUNK];
    {cout, sum_chunk}   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
    res_next            = res_q;
    res_next[k_q*CHUNK +: CHUNK] = sum_chunk;
    last                = (k_q == KW'(N - 1));
  end

`ifdef ADDSUB_FLAGS_EN
  logic carry_q, overflow_q, zero_q;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      c_q        <= 1'b0;
      k_q        <= '0;
`ifdef ADDSUB_FLAGS_EN
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry chain.
            a_q     <= inA;
            b_q     <= sel ? inB : ~inB;
            c_q     <= ~sel;
            k_q     <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          res_q <= res_next;
          c_q   <= cout;
          k_q   <= k_q + 1'b1;
          if (last) begin
            state_q <= StDone;
`ifdef ADDSUB_FLAGS_EN
            carry_q    <= cout;
            overflow_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (res_next[WIDTH-1] != a_q[WIDTH-1]);
            zero_q     <= (res_next == '0);
`endif
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out       = res_q;

`ifdef ADDSUB_FLAGS_EN
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
`else
  assign carry    = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_adder_subber_seq.sv
// Self-checking bench for adder_subber_seq: 64/16 main instance plus an 8/8 single-chunk instance.
// Flag expectations follow ADDSUB_FLAGS_EN (flags expected 0 when it is undefined).
module tb_adder_subber_seq;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [63:0] inA = '0, inB = '0;
  logic        sel = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, carry, overflow, zero;
  logic [63:0] dut_out;

  logic [7:0]  s_ina = '0, s_inb = '0;
  logic        s_sel = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic        s_in_ready, s_out_valid, s_carry, s_overflow, s_zero;
  logic [7:0]  s_out;

  int errors = 0;
  int checks = 0;

`ifdef ADDSUB_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  always #5 Clk = ~Clk;

  adder_subber_seq #(.WIDTH(64), .CHUNK(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .inA(inA), .inB(inB), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out(dut_out), .out_valid(out_valid), .out_ready(out_ready),
    .carry(carry), .overflow(overflow), .zero(zero)
  );

  adder_subber_seq #(.WIDTH(8), .CHUNK(8)) dut_small (
    .Clk(Clk), .Rst_n(Rst_n), .inA(s_ina), .inB(s_inb), .sel(s_sel), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .out(s_out), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .carry(s_carry), .overflow(s_overflow), .zero(s_zero)
  );

  // Reference: plain wide arithmetic, signed range check for overflow, unsigned compare for borrow.
  function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic s);
    logic [64:0]        u;
    logic signed [64:0] sv;
    logic               c, o, z;
    if (s) begin
      u  = {1'b0, a} + {1'b0, b};
      sv = $signed({a[63], a}) + $signed({b[63], b});
      c  = u[64];
    end else begin
      u  = {1'b0, a} - {1'b0, b};
      sv = $signed({a[63], a}) - $signed({b[63], b});
      c  = (a >= b);
    end
    o = (sv > 65'sd9223372036854775807) || (sv < -65'sd9223372036854775808);
    z = (u[63:0] == 64'd0);
    if (!FlagsOn) begin
      c = 1'b0; o = 1'b0; z = 1'b0;
    end
    return {u[63:0], c, o, z};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Drives one transaction; lat = edges from acceptance to out_valid, -1 on timeout.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        output logic [63:0] r, output logic [2:0] f, output int lat);
    int guard;
    @(negedge Clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    inA = a; inB = b; sel = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge Clk); #1;
    in_valid = 1'b0; inA = rnd64(); inB = rnd64(); sel = ~s;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    r = dut_out; f = {carry, overflow, zero};
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dut_out !== 64'd0 ||
        {carry, overflow, zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b out=%h flags=%b, want rdy=1 vld=0 out=0 flags=000",
               in_ready, out_valid, dut_out, {carry, overflow, zero});
    end
    @(negedge Clk); @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b/%b want 1/1", in_ready, s_in_ready);
    end
  endtask

  task automatic test_directed();
    logic [63:0] ta[5], tb_[5], te[5];
    logic        ts[5];
    logic [2:0]  tf[5];
    logic [63:0] r;
    logic [2:0]  f, ef;
    int          lat;
    ta[0] = 64'h0000_0000_0000_FFFF; tb_[0] = 64'd1; ts[0] = 1'b1;
    te[0] = 64'h0000_0000_0001_0000; tf[0] = 3'b000;
    ta[1] = 64'd5; tb_[1] = 64'd7; ts[1] = 1'b0;
    te[1] = 64'hFFFF_FFFF_FFFF_FFFE; tf[1] = 3'b000;
    ta[2] = 64'h1234_5678_9ABC_DEF0; tb_[2] = 64'h1234_5678_9ABC_DEF0; ts[2] = 1'b0;
    te[2] = 64'd0; tf[2] = 3'b101;
    ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb_[3] = 64'd1; ts[3] = 1'b1;
    te[3] = 64'h8000_0000_0000_0000; tf[3] = 3'b010;
    ta[4] = 64'hFFFF_FFFF_FFFF_FFFF; tb_[4] = 64'hFFFF_FFFF_FFFF_FFFF; ts[4] = 1'b1;
    te[4] = 64'hFFFF_FFFF_FFFF_FFFE; tf[4] = 3'b100;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb_[i], ts[i], r, f, lat);
      ef = FlagsOn ? tf[i] : 3'b000;
      checks++;
      if (r !== te[i]) begin
        errors++;
        $display("FAIL directed%0d_out: got %h want %h", i, r, te[i]);
      end
      checks++;
      if (f !== ef) begin
        errors++;
        $display("FAIL directed%0d_flags(c,o,z): got %b want %b", i, f, ef);
      end
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d want 4", i, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, r;
    logic        s;
    logic [2:0]  f;
    logic [66:0] exp;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 64'hFFFF_FFFF_FFFF_FFFF;
        1: a = 64'h8000_0000_0000_0000;
        default: a = rnd64();
      endcase
      case ($urandom_range(0, 3))
        0: b = 64'd0;
        1: b = 64'h7FFF_FFFF_FFFF_FFFF;
        default: b = rnd64();
      endcase
      s   = 1'($urandom);
      exp = model(a, b, s);
      run_op(a, b, s, r, f, lat);
      checks++;
      if (r !== exp[66:3] || f !== exp[2:0] || lat !== 4) begin
        errors++;
        $display("FAIL random%0d: a=%h b=%h sel=%b got out=%h flags=%b lat=%0d want out=%h flags=%b lat=4",
                 i, a, b, s, r, f, lat, exp[66:3], exp[2:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, held;
    logic [66:0] exp;
    int          guard;
    a = rnd64(); b = rnd64();
    exp = model(a, b, 1'b0);
    @(negedge Clk);
    inA = a; inB = b; sel = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge Clk); #1;
    guard = 0;
    while (!out_valid && guard < 20) begin
      inA = rnd64(); inB = rnd64(); sel = ~sel;
      @(posedge Clk); #1;
      guard++;
    end
    held = dut_out;
    checks++;
    if (out_valid !== 1'b1 || held !== exp[66:3] || {carry, overflow, zero} !== exp[2:0]) begin
      errors++;
      $display("FAIL bp_result: vld=%b out=%h flags=%b want vld=1 out=%h flags=%b",
               out_valid, held, {carry, overflow, zero}, exp[66:3], exp[2:0]);
    end
    for (int i = 0; i < 10; i++) begin
      inA = rnd64(); inB = rnd64(); sel = ~sel;
      @(posedge Clk); #1;
      checks++;
      if (dut_out !== exp[66:3] || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: out=%h vld=%b rdy=%b want out=%h vld=1 rdy=0",
                 i, dut_out, out_valid, in_ready, exp[66:3]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midcalc();
    logic [63:0] r;
    logic [2:0]  f;
    int          lat;
    @(negedge Clk);
    inA = 64'h1111_2222_3333_4444; inB = 64'h5555_6666_7777_8888; sel = 1'b1; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    @(posedge Clk); @(posedge Clk); #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (dut_out !== 64'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        {carry, overflow, zero} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: out=%h vld=%b rdy=%b flags=%b want out=0 vld=0 rdy=1 flags=000",
               dut_out, out_valid, in_ready, {carry, overflow, zero});
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    run_op(64'd3, 64'd4, 1'b1, r, f, lat);
    checks++;
    if (r !== 64'd7 || lat !== 4 || f !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_add: out=%h lat=%0d flags=%b want out=7 lat=4 flags=000", r, lat, f);
    end
  endtask

  task automatic test_single_chunk();
    int         lat;
    logic [2:0] ef;
    ef = FlagsOn ? 3'b101 : 3'b000;
    @(negedge Clk);
    s_ina = 8'hFF; s_inb = 8'h01; s_sel = 1'b1; s_in_valid = 1'b1;
    @(posedge Clk); #1;
    s_in_valid = 1'b0; s_ina = 8'h5A; s_inb = 8'hA5; s_sel = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
    checks++;
    if (s_out !== 8'h00 || lat !== 1 || {s_carry, s_overflow, s_zero} !== ef) begin
      errors++;
      $display("FAIL single_chunk: out=%h lat=%0d flags=%b want out=00 lat=1 flags=%b",
               s_out, lat, {s_carry, s_overflow, s_zero}, ef);
    end
    s_out_ready = 1'b1;
    @(posedge Clk); #1;
    s_out_ready = 1'b0;
    checks++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_chunk_release: rdy=%b want 1", s_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midcalc();
    test_single_chunk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_subber_seq.md
ADDER_SUBBER_SEQ -- requirements
Module: adder_subber_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 16, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 The block SHALL have port Clk, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port Rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port inA, input, WIDTH bits, first operand.
REQ-006 The block SHALL have port inB, input, WIDTH bits, second operand.
REQ-007 The block SHALL have port sel, input, 1 bit: 1 computes inA+inB, 0 computes inA-inB.
REQ-008 The block SHALL have port in_valid, input, 1 bit, operands and sel valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit, block can accept operands.
REQ-010 The block SHALL have port out, output, WIDTH bits, result modulo 2^WIDTH.
REQ-011 The block SHALL have port out_valid, output, 1 bit, out and flags valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-013 The block SHALL have ports carry, overflow and zero, each output, 1 bit, result flags.

Function
REQ-014 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 On a rising edge with in_valid=1 in IDLE, the block SHALL register inA, register inB (bitwise inverted when sel=0), set carry-in = ~sel, clear chunk index k, and enter CALC.
REQ-017 Each CALC cycle SHALL add chunk k of A, B and the running carry, write the sum into result bits [k*CHUNK +: CHUNK], store the chunk carry-out, and increment k.
REQ-018 The edge that processes chunk N-1 SHALL move the block to DONE; out_valid SHALL rise exactly N cycles after the accepting edge.
REQ-019 In DONE, out and the flags SHALL hold stable until an edge with out_ready=1, which SHALL return the block to IDLE.
REQ-020 The earliest next acceptance SHALL occur one cycle after the out handshake; in_valid SHALL be ignored outside IDLE.
REQ-021 Operand inputs SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the result.
REQ-022 For sel=0, carry SHALL be 1 when no borrow occurs (inA >= inB unsigned) and 0 otherwise.

Reset
REQ-023 Rst_n=0 SHALL, asynchronously and in any state including mid-CALC, force IDLE, out=0, out_valid=0, carry=0, overflow=0, zero=0 and k=0, and SHALL discard any in-flight operation.
REQ-024 in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-025 With macro ADDSUB_FLAGS_EN defined: carry SHALL equal the final chunk carry-out; overflow SHALL equal signed two's-complement overflow (operand sign bits after inversion equal and differing from the result sign); zero SHALL be 1 when out==0; all three SHALL be valid with out_valid.
REQ-026 Without ADDSUB_FLAGS_EN: carry, overflow and zero SHALL be tied to 0, no flag logic SHALL be built, and all other behaviour SHALL be unchanged.

Verification (WIDTH=64, CHUNK=16, N=4, ADDSUB_FLAGS_EN defined unless noted)
REQ-027 Add test: sel=1, A=0x000000000000FFFF, B=1 -> out=0x0000000000010000, carry=0, overflow=0, zero=0, out_valid exactly 4 cycles after the accepting edge.
REQ-028 Subtract test: sel=0, A=5, B=7 -> out=0xFFFFFFFFFFFFFFFE, carry=0; sel=0, A=B=0x123456789ABCDEF0 -> out=0, zero=1, carry=1.
REQ-029 Overflow test: sel=1, A=0x7FFFFFFFFFFFFFFF, B=1 -> out=0x8000000000000000, overflow=1, carry=0; sel=1, A=B=0xFFFFFFFFFFFFFFFF -> out=0xFFFFFFFFFFFFFFFE, carry=1, overflow=0.
REQ-030 Backpressure test: out_ready=0 for 10 cycles in DONE while in_valid=1 and inputs toggle -> out stable, in_ready=0, no new acceptance; out_ready=1 -> IDLE next cycle.
REQ-031 Reset test: assert Rst_n=0 two cycles after acceptance -> all outputs 0 and in_ready=1 without waiting for a clock edge; after release, a new add of 3+4 -> out=7.
REQ-032 Build test: WIDTH=8, CHUNK=8, without ADDSUB_FLAGS_EN: sel=1, 0xFF+0x01 -> out=0x00, out_valid 1 cycle after the accepting edge, carry/overflow/zero=0.
